// File: rtl/muldiv_pkg.sv
// Shared opcode constants, FSM state type and op3 decode helpers for muldiv_alu.
package muldiv_pkg;

  localparam logic [5:0] OP3_UMUL = 6'h0A;
  localparam logic [5:0] OP3_SMUL = 6'h0B;
  localparam logic [5:0] OP3_UDIV = 6'h0E;
  localparam logic [5:0] OP3_SDIV = 6'h0F;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} muldiv_state_t;

  // op3[4] is the cc bit and op3[0] the signed bit; mask them off to find the base op.
  function automatic logic op3_is_div(input logic [5:0] op3);
    return (op3 & ~6'h11) == OP3_UDIV;
  endfunction

  function automatic logic op3_known(input logic [5:0] op3);
    return ((op3 & ~6'h11) == OP3_UMUL) || op3_is_div(op3);
  endfunction

  function automatic logic op3_signed(input logic [5:0] op3);
    return ((op3 & ~6'h10) == OP3_SMUL) || ((op3 & ~6'h10) == OP3_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_alu_if.sv
// Request/result bundle between the execute stage and muldiv_alu.
interface muldiv_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       op3;
  logic [WIDTH-1:0] a, b;
  logic             wry;
  logic [WIDTH-1:0] yin;
  logic [WIDTH-1:0] out, yout;
  logic             n, z, v, c;
  logic             busy, done, divzero, unimp;

  modport master (
    output start, op3, a, b, wry, yin,
    input  out, yout, n, z, v, c, busy, done, divzero, unimp
  );

  modport slave (
    input  start, op3, a, b, wry, yin,
    output out, yout, n, z, v, c, busy, done, divzero, unimp
  );
endinterface

// File: rtl/restoring_div.sv
// Iterative restoring divider: 2W/W unsigned, one quotient bit per cycle for WIDTH cycles.
module restoring_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quo,
  output logic               ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   part;
  logic             ge;

  // quo doubles as the shift register feeding dividend low bits into the remainder
  assign part = {rem, quo[WIDTH-1]};
  assign ge   = part >= {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      dsr <= '0;
      quo <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      rem <= dividend[2*WIDTH-1:WIDTH];
      quo <= dividend[WIDTH-1:0];
      dsr <= divisor;
      ovf <= dividend[2*WIDTH-1:WIDTH] >= divisor;
      cnt <= CW'(WIDTH);
    end else if (cnt != '0) begin
      rem <= ge ? WIDTH'(part - {1'b0, dsr}) : part[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/muldiv_alu.sv
// SPARC V8 UMUL/SMUL/UDIV/SDIV (+cc) unit beside the integer ALU; owns Y.
// Define MULDIV_DIV_EN to build the divide path; otherwise divide opcodes report Unimp.
module muldiv_alu #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_alu_if.slave bus
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t      state, nxt;
  logic [CW-1:0]      cnt;
  logic               cc_r, sgn_r, div_r, neg_r, bz_r, unimp_r;
  logic [WIDTH-1:0]   ph, pl, mc;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   ma, mb, dq, res;
  logic               sgn_in, supp, dsgn, neg_in, dbig, ovf;

  assign sgn_in = op3_signed(bus.op3);
  assign ma     = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mb     = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign neg_in = sgn_in && (dsgn ^ bus.b[WIDTH-1]);
  assign psum   = {1'b0, ph} + (pl[0] ? {1'b0, mc} : '0);

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   ydiv;
  logic [2*WIDTH-1:0] dvd, dmag;

  // write-first: a WRY in the Start cycle supplies the dividend high word
  assign ydiv = bus.wry ? bus.yin : bus.yout;
  assign dvd  = {ydiv, bus.a};
  assign dmag = (sgn_in && ydiv[WIDTH-1]) ? -dvd : dvd;
  assign dsgn = op3_is_div(bus.op3) ? ydiv[WIDTH-1] : bus.a[WIDTH-1];
  assign supp = op3_known(bus.op3);

  restoring_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (state == IDLE && bus.start && op3_is_div(bus.op3)),
    .dividend (dmag),
    .divisor  (mb),
    .quo      (dq),
    .ovf      (dbig)
  );
`else
  assign dsgn = bus.a[WIDTH-1];
  assign supp = op3_known(bus.op3) && !op3_is_div(bus.op3);
  assign dq   = '0;
  assign dbig = 1'b0;
`endif

  always_comb begin
    prod_s = neg_r ? -{ph, pl} : {ph, pl};
    ovf    = 1'b0;
    res    = prod_s[WIDTH-1:0];
    if (div_r) begin
      if (sgn_r) begin
        // a negative quotient may reach -2^(W-1); a positive one only 2^(W-1)-1
        ovf = dbig || (neg_r ? (dq > HALF) : dq[WIDTH-1]);
        res = ovf ? (neg_r ? HALF : ~HALF) : (neg_r ? -dq : dq);
      end else begin
        ovf = dbig;
        res = ovf ? '1 : dq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (bus.start) nxt = !supp ? FIN : (op3_is_div(bus.op3) ? DIV : MUL);
      MUL, DIV: if (cnt == CW'(WIDTH - 1)) nxt = FIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      {cc_r, sgn_r, div_r, neg_r, bz_r, unimp_r} <= '0;
      ph <= '0;
      pl <= '0;
      mc <= '0;
      bus.out  <= '0;
      bus.yout <= '0;
      {bus.n, bus.z, bus.v, bus.c} <= '0;
      {bus.busy, bus.done, bus.divzero, bus.unimp} <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.divzero <= 1'b0;
      bus.unimp   <= 1'b0;
      if (bus.wry && !bus.busy) bus.yout <= bus.yin;
      case (state)
        IDLE: if (bus.start) begin
          cc_r     <= bus.op3[4];
          sgn_r    <= sgn_in;
          div_r    <= op3_is_div(bus.op3);
          neg_r    <= neg_in;
          bz_r     <= bus.b == '0;
          unimp_r  <= !supp;
          bus.busy <= supp;
          cnt      <= '0;
          ph       <= '0;
          pl       <= ma;
          mc       <= mb;
        end
        MUL: begin
          {ph, pl} <= {psum, pl[WIDTH-1:1]};
          cnt      <= cnt + 1'b1;
        end
        DIV: cnt <= cnt + 1'b1;
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          if (unimp_r) begin
            bus.unimp <= 1'b1;
          end else if (div_r && bz_r) begin
            bus.divzero <= 1'b1;
            bus.out     <= '0;
          end else begin
            bus.out <= res;
            if (!div_r) bus.yout <= prod_s[2*WIDTH-1:WIDTH];
            if (cc_r) {bus.n, bus.z, bus.v, bus.c} <= {res[WIDTH-1], res == '0, ovf, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_alu.sv
// Bench for muldiv_alu: directed vectors, multi-cycle corner sequences, random ops vs arithmetic model.
module tb_muldiv_alu;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] out, y;
    logic [3:0]  f;
    logic        dz, ui;
    int          lat;
  } exp_t;

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [31:0] y0, a, b, eout, ey;
    logic [3:0]  ef;
    logic        edz;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  int          passed = 0, total = 0;
  logic [31:0] m_out = '0, m_y = '0;
  logic [3:0]  m_f = '0;
  vec_t        tv[10];
  logic [5:0]  ops[8];

  muldiv_alu_if #(.WIDTH(W)) bus ();
  muldiv_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  // Expected result from the instruction semantics using 64-bit arithmetic.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] y, input logic [31:0] pout, input logic [3:0] pf);
    exp_t        e;
    logic [5:0]  base;
    logic [63:0] p, d, dm, qm;
    logic [31:0] bm, r;
    logic        neg, ov, is_div;
    longint      sa, sb;
    e.out = pout; e.y = y; e.f = pf; e.dz = 1'b0; e.ui = 1'b0; e.lat = W + 1;
    base   = op & ~6'h10;
    is_div = (base == OP3_UDIV) || (base == OP3_SDIV);
    if (!(is_div || base == OP3_UMUL || base == OP3_SMUL) || (is_div && !DIV_EN)) begin
      e.ui = 1'b1; e.lat = 1;
      return e;
    end
    ov = 1'b0;
    if (!is_div) begin
      if (base == OP3_SMUL) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end else p = {32'h0, a} * {32'h0, b};
      r = p[31:0]; e.y = p[63:32];
    end else if (b == 32'h0) begin
      e.out = '0; e.dz = 1'b1;
      return e;
    end else begin
      d = {y, a};
      if (base == OP3_UDIV) begin
        qm = d / {32'h0, b};
        ov = qm[63:32] != 32'h0;
        r  = ov ? 32'hFFFF_FFFF : qm[31:0];
      end else begin
        neg = y[31] ^ b[31];
        dm  = y[31] ? -d : d;
        bm  = b[31] ? -b : b;
        qm  = dm / {32'h0, bm};
        ov  = neg ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF);
        r   = neg ? -qm[31:0] : qm[31:0];
        if (ov) r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end
    e.out = r;
    if (op[4]) e.f = {r[31], r == 32'h0, ov, 1'b0};
    return e;
  endfunction

  task automatic wr_y(input logic [31:0] v);
    bus.wry = 1'b1; bus.yin = v;
    @(negedge clk);
    bus.wry = 1'b0;
    m_y = v;
    check("wry", bus.yout, v);
  endtask

  task automatic do_op(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic wy, input logic [31:0] yv, input exp_t e, input bit b2b);
    int lat;
    bus.start = 1'b1; bus.op3 = op; bus.a = a; bus.b = b; bus.wry = wy; bus.yin = yv;
    @(negedge clk);
    bus.start = 1'b0; bus.wry = 1'b0;
    check({nm, ".busy"}, bus.busy, e.lat > 1);
    lat = 0;
    while (!bus.done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check({nm, ".lat"}, lat, e.lat);
    check({nm, ".out"}, bus.out, e.out);
    check({nm, ".y"}, bus.yout, e.y);
    check({nm, ".nzvc"}, {bus.n, bus.z, bus.v, bus.c}, e.f);
    check({nm, ".dz_ui_busy"}, {bus.divzero, bus.unimp, bus.busy}, {e.dz, e.ui, 1'b0});
    m_out = e.out; m_y = e.y; m_f = e.f;
    if (!b2b) begin
      @(negedge clk);
      check({nm, ".clr"}, {bus.done, bus.divzero, bus.unimp}, 3'b000);
    end
  endtask

  initial begin
    exp_t        e;
    int          lat, nd;
    logic [5:0]  op;
    logic [31:0] a, b, yv, yeff;
    logic        wy;

    tv[0] = '{"umulcc",      6'h1A, 32'h0,         32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 32'h1,         4'b1000, 1'b0};
    tv[1] = '{"smul",        6'h0B, 32'h0,         32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b1000, 1'b0};
    tv[2] = '{"udivcc",      6'h1E, 32'h0,         32'd100,       32'd7,         32'd14,        32'h0,         4'b0000, 1'b0};
    tv[3] = '{"udivcc_ovf",  6'h1E, 32'h1,         32'h0,         32'h1,         32'hFFFF_FFFF, 32'h1,         4'b1010, 1'b0};
    tv[4] = '{"sdivcc_neg",  6'h1F, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFF, 4'b1000, 1'b0};
    tv[5] = '{"udiv_zero",   6'h0E, 32'h0,         32'd5,         32'h0,         32'h0,         32'h0,         4'b1000, 1'b1};
    tv[6] = '{"smulcc_zero", 6'h1B, 32'h0,         32'h0,         32'd12345,     32'h0,         32'h0,         4'b0100, 1'b0};
    tv[7] = '{"sdivcc_ovf",  6'h1F, 32'h0,         32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 32'h0,         4'b0010, 1'b0};
    tv[8] = '{"sdivcc_min",  6'h1F, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1,         32'h8000_0000, 32'hFFFF_FFFF, 4'b1000, 1'b0};
    tv[9] = '{"umulcc_max",  6'h1A, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 4'b0000, 1'b0};
    ops = '{OP3_UMUL, OP3_SMUL, OP3_UDIV, OP3_SDIV,
            OP3_UMUL | 6'h10, OP3_SMUL | 6'h10, OP3_UDIV | 6'h10, OP3_SDIV | 6'h10};

    reset = 1'b1;
    bus.start = 1'b0; bus.op3 = '0; bus.a = '0; bus.b = '0; bus.wry = 1'b0; bus.yin = '0;
    repeat (3) @(negedge clk);
    check("reset.out_y", {bus.out, bus.yout}, 64'h0);
    check("reset.flags_ctl", {bus.n, bus.z, bus.v, bus.c, bus.busy, bus.done, bus.divzero, bus.unimp}, 8'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      wr_y(tv[i].y0);
      e.out = tv[i].eout; e.y = tv[i].ey; e.f = tv[i].ef; e.dz = tv[i].edz; e.ui = 1'b0; e.lat = W + 1;
`ifndef MULDIV_DIV_EN
      if (op3_is_div(tv[i].op)) begin
        e.out = m_out; e.y = m_y; e.f = m_f; e.dz = 1'b0; e.ui = 1'b1; e.lat = 1;
      end
`endif
      do_op(tv[i].nm, tv[i].op, tv[i].a, tv[i].b, 1'b0, 32'h0, e, 1'b0);
    end

    e = model(6'h00, 32'h55, 32'h66, m_y, m_out, m_f);
    do_op("op3_00", 6'h00, 32'h55, 32'h66, 1'b0, 32'h0, e, 1'b0);

    // A second Start while busy must neither restart nor queue.
    bus.op3 = 6'h1A; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 4 * W) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.op3 = 6'h0B; bus.a = 32'd7; bus.b = 32'd7;
      end else bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("busy_start.lat", lat, W + 1);
    check("busy_start.out", bus.out, 32'd15);
    check("busy_start.nzvc", {bus.n, bus.z, bus.v, bus.c}, 4'b0000);
    nd = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("busy_start.extra_done", nd, 0);
    m_out = 32'd15; m_y = 32'h0; m_f = 4'b0000;

    // Reset part-way through a multiply abandons it without a Done.
    wr_y(32'hA5A5);
    bus.op3 = 6'h1A; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.busy", bus.busy, 1'b0);
    check("midrst.out_y", {bus.out, bus.yout}, 64'h0);
    nd = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("midrst.no_done", nd, 0);
    m_out = '0; m_y = '0; m_f = '0;

    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      a  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 300);
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      wy = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       yv = 32'h0;
        1:       yv = 32'hFFFF_FFFF;
        default: yv = $urandom;
      endcase
      yeff = wy ? yv : m_y;
      e = model(op, a, b, yeff, m_out, m_f);
      do_op($sformatf("rnd%0d_op%02h", i, op), op, a, b, wy, yv, e, bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
